gbsha_fir_ntap: RTL
===================

// Module: gbsha_fir_ntap
// PURPOSE
//  Parametrised N-tap direct-form FIR filter core, successor to the single-tap load-then-stream filter.
//  After reset it serially loads N_TAPS signed coefficients from the sample bus, then filters a valid-qualified
//  sample stream with a registered output. Sits behind the 8-bit pad wrapper; the wrapper maps io pins to these ports.
// PARAMETERS
//  N_TAPS     4   number of taps / coefficients (>=1)
//  BW_in      6   signed width of samples and coefficients
//  BW_out     8   signed output width (low bits of scaled accumulator)
//  OUT_SHIFT  0   arithmetic right shift applied to accumulator before output selection
// PORTS
//  clk         in   1       rising-edge clock, single clock domain
//  reset_n     in   1       asynchronous active-low reset
//  x_in        in   BW_in   signed sample (RUN) or coefficient word (LOAD)
//  in_valid    in   1       x_in qualifier; nothing is consumed when low
//  coef_reload in   1       request return to LOAD (sampled at posedge)
//  y_out       out  BW_out  signed filter output, registered
//  out_valid   out  1       one-cycle pulse: y_out updated this cycle
//  loading     out  1       high while in LOAD state
// BEHAVIOUR
//  Reset (reset_n low, async): state=LOAD, load index=0, coefficients=0, delay line=0, y_out=0, out_valid=0, loading=1.
//  LOAD: each cycle with in_valid=1 writes x_in to c[idx], idx++; idx==N_TAPS-1 write -> RUN next cycle.
//    First word loaded is c[0] (applied to newest sample). in_valid=0 holds idx. out_valid stays 0.
//  RUN: cycle with in_valid=1: delay line shifts (d[0]<=x_in, d[k]<=d[k-1]);
//    acc = sum_k c[k]*d'[k] using the post-shift line (x_in as d'[0]); y_out <= acc>>>OUT_SHIFT [BW_out-1:0];
//    out_valid=1 next cycle. Latency: sample at edge n -> y_out/out_valid valid after edge n (1 cycle).
//    in_valid=0: delay line and y_out hold, out_valid=0.
//  coef_reload=1 (any state): next state LOAD, idx=0, delay line cleared, y_out holds, out_valid=0.
//    Takes priority over in_valid in the same cycle (that x_in is dropped). Old coefficients kept until overwritten.
//  Widths: product 2*BW_in signed; accumulator BW_ACC = 2*BW_in + clog2(N_TAPS), sign-extended; no overflow internally.
//  Output selection default: two's-complement wrap (truncate high bits).
//  Reset mid-load or mid-stream: immediate async clear as above; no partial coefficient set survives.
// CONFIGURATION
//  GBSHA_FIR_SAT_EN defined: scaled accumulator saturates to [-2^(BW_out-1), 2^(BW_out-1)-1] before output.
//  Not defined: output wraps (low BW_out bits). No other behaviour differs; latency identical.
// STRUCTURE
//  Package gbsha_fir_pkg: state enum {LOAD, RUN}; BW_ACC function; saturation limit constants helper.
//  Sub-module gbsha_fir_tap: one coefficient register + delay register + signed multiplier, chained N_TAPS times
//    via generate; top holds FSM, load index, adder tree/accumulate, output scaling and register.
// TESTING (N_TAPS=4, BW_in=6, BW_out=8, OUT_SHIFT=0 unless stated)
//  1. Load 1,0,0,0; feed 5 -> y_out=5, out_valid=1 one cycle later; feed -7 -> y_out=-7 (0xF9).
//  2. Load 1,1,1,1; impulse 3 then zeros -> y_out sequence 3,3,3,6? no: 3,3,3,3,0 (moving sum of one impulse).
//  3. Load -32 x4; feed -32 x4 -> acc=4096; no macro: y_out=0x00; GBSHA_FIR_SAT_EN: y_out=127 (0x7F).
//  4. RUN with in_valid toggling 1,0,1: out_valid pulses 1,0,1; y_out and delay line hold on the idle cycle.
//  5. Reset_n low after 2 coefficient words -> y_out=0, loading=1 immediately; 4 new words needed before RUN.
//  6. coef_reload with in_valid=1 in RUN -> sample dropped, loading=1 next cycle, delay line zero; reload 2,0,0,0,
//     feed 10 -> y_out=20.
//  Bench also checks: out_valid never high while loading=1; OUT_SHIFT=2 with acc=20 -> y_out=5.

Source files
------------

// File: rtl/gbsha_fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gbsha_fir_pkg
//  Description : Shared types and width helpers for the gbsha_fir_ntap FIR
//                core: controller state encoding, accumulator width, load
//                index width and output saturation limits.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package gbsha_fir_pkg;

    // Controller state: coefficients are loaded first, then samples stream.
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } fir_state_e;

    // Full-precision accumulator width. The sum of N_TAPS products of two
    // BW_in-bit signed values needs clog2(N_TAPS) growth bits, so it
    // cannot overflow.
    function automatic int bw_acc(input int bw_in, input int n_taps);
        return 2 * bw_in + $clog2(n_taps);
    endfunction

    // Width of the coefficient load index. It is kept at least 1 bit wide
    // so that a single-tap build still has a legal vector.
    function automatic int idx_w(input int n_taps);
        return (n_taps > 1) ? $clog2(n_taps) : 1;
    endfunction

    // Largest value representable in a bw_out-bit signed output.
    function automatic int sat_hi(input int bw_out);
        return (1 << (bw_out - 1)) - 1;
    endfunction

    // Smallest value representable in a bw_out-bit signed output.
    function automatic int sat_lo(input int bw_out);
        return -(1 << (bw_out - 1));
    endfunction

endpackage : gbsha_fir_pkg
`default_nettype wire

// File: rtl/gbsha_fir_tap.sv
`default_nettype none
// ============================================================================
//  Module      : gbsha_fir_tap
//  Description : One FIR tap. It holds a coefficient register and a delay
//                register and contains a signed multiplier. The product uses
//                the tap's incoming sample (d_i), which is the value the delay
//                register takes on this shift. The sum therefore sees the
//                post-shift delay line in the same cycle.
//  Ports       : clk        - clock
//                reset_n    - asynchronous active-low reset
//                clear_i    - clear the delay register (takes priority over shift)
//                coef_we_i  - write coef_i into the coefficient register
//                coef_i     - coefficient word
//                shift_i    - advance the delay line (d_q <= d_i)
//                d_i        - sample arriving from the previous stage
//                d_o        - registered sample, passed to the next stage
//                prod_o     - coef * d_i, full 2*BW_in-bit signed product
//  Revision    : 1.0 - initial release
// ============================================================================
module gbsha_fir_tap #(
    parameter int BW_in = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear_i,
    input  logic                      coef_we_i,
    input  logic signed [BW_in-1:0]   coef_i,
    input  logic                      shift_i,
    input  logic signed [BW_in-1:0]   d_i,
    output logic signed [BW_in-1:0]   d_o,
    output logic signed [2*BW_in-1:0] prod_o
);

    localparam int c_PW = 2 * BW_in;

    logic signed [BW_in-1:0] coef_q, coef_d;
    logic signed [BW_in-1:0] dly_q,  dly_d;

    always_comb begin
        coef_d = coef_q;
        if (coef_we_i) begin
            coef_d = coef_i;
        end
    end

    always_comb begin
        dly_d = dly_q;
        if (clear_i) begin
            dly_d = '0;
        end else if (shift_i) begin
            dly_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coef_q <= '0;
            dly_q  <= '0;
        end else begin
            coef_q <= coef_d;
            dly_q  <= dly_d;
        end
    end

    // Sign-extend both operands to the product width so that the multiply
    // is carried out at full precision.
    assign prod_o = c_PW'(coef_q) * c_PW'(d_i);
    assign d_o    = dly_q;

endmodule : gbsha_fir_tap
`default_nettype wire

// File: rtl/gbsha_fir_ntap.sv
`default_nettype none
// ============================================================================
//  Module      : gbsha_fir_ntap
//  Description : Parametrised N-tap direct-form FIR core.
//                After reset, the core loads N_TAPS signed coefficients from
//                x_in, one per valid cycle. The first word goes to the tap
//                that multiplies the newest sample. The core then filters the
//                valid-qualified sample stream with a registered output that
//                has one cycle of latency.
//                A coef_reload request returns the core to the load state and
//                clears the delay line. The old coefficients stay in place
//                until they are overwritten.
//  Config      : GBSHA_FIR_SAT_EN - when defined, the scaled accumulator
//                saturates to the BW_out signed range. When not defined,
//                the output keeps the low BW_out bits (two's-complement wrap).
//  Ports       : clk         - clock, rising edge
//                reset_n     - asynchronous active-low reset
//                x_in        - sample (RUN) or coefficient word (LOAD)
//                in_valid    - qualifies x_in
//                coef_reload - request a return to LOAD
//                y_out       - registered filter output
//                out_valid   - one-cycle pulse when y_out is updated
//                loading     - high while in LOAD
//  Revision    : 1.0 - initial release
// ============================================================================
module gbsha_fir_ntap
    import gbsha_fir_pkg::*;
#(
    parameter int N_TAPS    = 4,
    parameter int BW_in     = 6,
    parameter int BW_out    = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [BW_in-1:0]  x_in,
    input  logic                     in_valid,
    input  logic                     coef_reload,
    output logic signed [BW_out-1:0] y_out,
    output logic                     out_valid,
    output logic                     loading
);

    localparam int c_BW_ACC = bw_acc(BW_in, N_TAPS);
    localparam int c_IDX_W  = idx_w(N_TAPS);
    localparam int c_PW     = 2 * BW_in;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_TAPS - 1);

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    fir_state_e           state_q, state_d;
    logic [c_IDX_W-1:0]   idx_q,   idx_d;

    logic                 w_load_wr;   // coefficient word accepted this cycle
    logic                 w_shift;     // sample accepted this cycle

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic. A reload overrides everything, including a valid
    // word or sample presented in the same cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (coef_reload) begin
            state_d = ST_LOAD;
            idx_d   = '0;
        end else if (w_load_wr) begin
            if (idx_q == c_IDX_LAST) begin
                state_d = ST_RUN;
                idx_d   = '0;
            end else begin
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    // Output / control decode
    always_comb begin
        loading   = (state_q == ST_LOAD);
        w_load_wr = (state_q == ST_LOAD) && in_valid && !coef_reload;
        w_shift   = (state_q == ST_RUN)  && in_valid && !coef_reload;
    end

    // ------------------------------------------------------------------
    // Tap chain
    // ------------------------------------------------------------------
    logic               [N_TAPS-1:0] w_coef_we;
    logic signed [BW_in-1:0]         w_tap_in [N_TAPS];
    logic signed [BW_in-1:0]         w_dly    [N_TAPS];
    logic signed [c_PW-1:0]          w_prod   [N_TAPS];

    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        if (k == 0) begin : g_head
            assign w_tap_in[k] = x_in;
        end else begin : g_chain
            assign w_tap_in[k] = w_dly[k-1];
        end

        assign w_coef_we[k] = w_load_wr && (idx_q == c_IDX_W'(k));

        gbsha_fir_tap #(
            .BW_in     (BW_in)
        ) u_tap (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear_i   (coef_reload),
            .coef_we_i (w_coef_we[k]),
            .coef_i    (x_in),
            .shift_i   (w_shift),
            .d_i       (w_tap_in[k]),
            .d_o       (w_dly[k]),
            .prod_o    (w_prod[k])
        );
    end

    // The oldest sample leaves the line here and nothing reads it.
    logic w_unused_tail;
    assign w_unused_tail = ^w_dly[N_TAPS-1];

    // ------------------------------------------------------------------
    // Accumulate and scale
    // ------------------------------------------------------------------
    logic signed [c_BW_ACC-1:0] w_acc;
    logic signed [c_BW_ACC-1:0] w_scaled;
    logic signed [BW_out-1:0]   w_out;

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            w_acc = w_acc + c_BW_ACC'(w_prod[k]);
        end
    end

    assign w_scaled = w_acc >>> OUT_SHIFT;

`ifdef GBSHA_FIR_SAT_EN
    // Clamping is needed only when the output is narrower than the
    // accumulator. Otherwise every scaled value already fits.
    localparam bit c_SAT_NEEDED = (BW_out < c_BW_ACC);
    localparam logic signed [c_BW_ACC-1:0] c_SAT_HI = c_BW_ACC'(sat_hi(BW_out));
    localparam logic signed [c_BW_ACC-1:0] c_SAT_LO = c_BW_ACC'(sat_lo(BW_out));
    localparam logic signed [BW_out-1:0]   c_OUT_MAX = BW_out'(sat_hi(BW_out));
    localparam logic signed [BW_out-1:0]   c_OUT_MIN = BW_out'(sat_lo(BW_out));

    always_comb begin
        w_out = BW_out'(w_scaled);
        if (c_SAT_NEEDED) begin
            if (w_scaled > c_SAT_HI) begin
                w_out = c_OUT_MAX;
            end else if (w_scaled < c_SAT_LO) begin
                w_out = c_OUT_MIN;
            end
        end
    end
`else
    assign w_out = BW_out'(w_scaled);
`endif

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic signed [BW_out-1:0] y_q, y_d;
    logic                     ov_q, ov_d;

    always_comb begin
        y_d  = w_shift ? w_out : y_q;
        ov_d = w_shift;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q  <= '0;
            ov_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            ov_q <= ov_d;
        end
    end

    assign y_out     = y_q;
    assign out_valid = ov_q;

endmodule : gbsha_fir_ntap
`default_nettype wire
